ifid_buffer: RTL
================

IFID_BUFFER -- requirements
Module: ifid_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 2: number of instruction entries (power of two, 2..8).
REQ-002 SHALL have parameter NOP_INSTR, default 16'h0800: instruction presented when no valid entry exists.
REQ-003 SHALL have port clk  input  1: single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1: fetch offers an instruction this cycle (stallmem Done).
REQ-006 SHALL have port in_instr  input  16: fetched instruction.
REQ-007 SHALL have port in_pc_curr  input  16: address of the fetched instruction.
REQ-008 SHALL have port in_pc_next  input  16: sequential successor PC (PC+2).
REQ-009 SHALL have port flush  input  1: branch/jump resolved taken; discard all held entries.
REQ-010 SHALL have port stall  input  1: decode hazard; hold the head entry.
REQ-011 SHALL have port full  output  1: no free entry; fetch must hold its PC.
REQ-012 SHALL have port out_valid  output  1: head entry valid for decode.
REQ-013 SHALL have port IFID_instr  output  16: head instruction, or NOP_INSTR when empty.
REQ-014 SHALL have port IFID_PC_curr  output  16: head instruction address, 16'h0000 when empty.
REQ-015 SHALL have port IFID_PC_Next  output  16: head successor PC, 16'h0000 when empty.
REQ-016 SHALL have port err  output  1: sticky overflow error.

Function
REQ-017 SHALL be a circular FIFO of DEPTH entries {instr, pc_curr, pc_next}, with read pointer, write pointer, and a count of width clog2(DEPTH)+1.
REQ-018 SHALL define push = in_valid & ~full & ~flush, and pop = out_valid & ~stall & ~flush.
REQ-019 SHALL on push write the entry at the write pointer and advance the write pointer modulo DEPTH.
REQ-020 SHALL on pop advance the read pointer modulo DEPTH.
REQ-021 SHALL on simultaneous push and pop keep count unchanged and advance both pointers, including when count==DEPTH-1 and when count==1.
REQ-022 SHALL drive full = (count==DEPTH) combinationally from registered count only, never from stall or pop.
REQ-023 SHALL drive out_valid = (count!=0), and present the head outputs combinationally from the entry at the read pointer (zero-latency head).
REQ-024 SHALL give first-word latency of 1 cycle: an instruction pushed at edge N appears on IFID_* with out_valid=1 after edge N.
REQ-025 SHALL on flush at an edge set count=0 and rptr=wptr=0, and drop any same-cycle in_valid; flush SHALL have priority over push, pop and stall.
REQ-026 SHALL not modify err on flush.
REQ-027 SHALL when in_valid=1 while full=1 and flush=0 drop the input, leave state unchanged, and set err=1 at that edge.
REQ-028 SHALL keep err set until reset.
REQ-029 SHALL when stall=1 and flush=0 hold the head entry and its outputs stable while still accepting pushes if not full.
REQ-030 SHALL when empty drive IFID_instr=NOP_INSTR, IFID_PC_*=16'h0000 and out_valid=0 regardless of stall.
REQ-031 SHALL never bypass in_instr to IFID_instr in the cycle it arrives.

Reset
REQ-032 SHALL on rst=0 asynchronously clear count, rptr, wptr and err, giving full=0, out_valid=0, IFID_instr=NOP_INSTR, IFID_PC_curr=IFID_PC_Next=16'h0000.
REQ-033 SHALL leave entry storage contents unreset; the empty state masks them.
REQ-034 SHALL resume normal operation at the first rising edge after rst deasserts, including when reset is asserted mid-stream with entries held.

Verification
REQ-035 SHALL cover this scenario: reset, then push {1234, pc 0000, next 0002} at edge 1 -> after edge 1 IFID_instr=1234, PC_curr=0000, PC_Next=0002, out_valid=1.
REQ-036 SHALL cover this scenario: stall=1, push 2 entries (DEPTH=2) -> full=1, head unchanged; a third in_valid -> err=1, entries intact; stall=0 -> entries pop in order.
REQ-037 SHALL cover this scenario: 2 entries held, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0, IFID_instr=0800, err unchanged.
REQ-038 SHALL cover this scenario: count=1, push and pop on the same edge for 10 consecutive cycles -> count stays 1, outputs track each instruction one cycle late, pointers wrap without loss.
REQ-039 SHALL cover this scenario: rst pulsed low between clock edges while full=1 and err=1 -> immediately full=0, out_valid=0, err=0, IFID_instr=0800.
REQ-040 SHALL cover this scenario: empty with stall=1 -> IFID_instr=0800 and out_valid=0 held steady.

Source files
------------

// File: rtl/ifid_buffer.sv
// IF/ID pipeline buffer: small circular FIFO between fetch and decode.
// Head entry is presented combinationally; empty buffer presents a NOP with zero PCs.
module ifid_buffer #(
  parameter int          DEPTH     = 2,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_instr,
  input  logic [15:0] in_pc_curr,
  input  logic [15:0] in_pc_next,
  input  logic        flush,
  input  logic        stall,
  output logic        full,
  output logic        out_valid,
  output logic [15:0] IFID_instr,
  output logic [15:0] IFID_PC_curr,
  output logic [15:0] IFID_PC_Next,
  output logic        err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [15:0]   instr_mem   [DEPTH];
  logic [15:0]   pc_curr_mem [DEPTH];
  logic [15:0]   pc_next_mem [DEPTH];

  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic          push, pop;

  assign full      = (count_q == CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign err       = err_q;

  assign push = in_valid & ~full & ~flush;
  assign pop  = out_valid & ~stall & ~flush;

  // DEPTH is a power of two, so pointer increments wrap naturally.
  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    err_d   = err_q;
    if (flush) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
      if (in_valid && full) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Entry storage is deliberately unreset; an empty count masks stale contents.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wptr_q]   <= in_instr;
      pc_curr_mem[wptr_q] <= in_pc_curr;
      pc_next_mem[wptr_q] <= in_pc_next;
    end
  end

  always_comb begin
    IFID_instr   = NOP_INSTR;
    IFID_PC_curr = 16'h0000;
    IFID_PC_Next = 16'h0000;
    if (out_valid) begin
      IFID_instr   = instr_mem[rptr_q];
      IFID_PC_curr = pc_curr_mem[rptr_q];
      IFID_PC_Next = pc_next_mem[rptr_q];
    end
  end

endmodule
